// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if
// Bundles every signal of the register-file write-port arbiter except the
// clock and reset.
//   slave  modport : the arbiter side (rf_wb_arbiter)
//   master modport : the pipeline / long-latency unit / register file side
// Signal groups:
//   wb_*       writeback stage request (no backpressure)
//   lu_*       long-latency unit issue notice and valid/ready result channel
//   id_*       decode-stage operand indices and the resulting stall
//   pipe_hold  asks the pipeline to keep wb_we low for one cycle
//   RFWr/A3/WD registered register-file write port
interface rf_wb_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wd;
  logic        lu_issue;
  logic [4:0]  lu_issue_rd;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_wd;
  logic        lu_ready;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_stall;
  logic        pipe_hold;
  logic        RFWr;
  logic [4:0]  A3;
  logic [31:0] WD;

  modport slave (
    input  wb_we, wb_rd, wb_wd,
    input  lu_issue, lu_issue_rd, lu_valid, lu_rd, lu_wd,
    output lu_ready,
    input  id_rs1, id_rs2, id_rd,
    output id_stall, pipe_hold,
    output RFWr, A3, WD
  );

  modport master (
    output wb_we, wb_rd, wb_wd,
    output lu_issue, lu_issue_rd, lu_valid, lu_rd, lu_wd,
    input  lu_ready,
    output id_rs1, id_rs2, id_rd,
    input  id_stall, pipe_hold,
    input  RFWr, A3, WD
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Owns the single register-file write port. Each cycle it grants the port to
// one of: the skid entry, a starved long-latency result, the writeback stage,
// or a long-latency result, and registers the winner onto RFWr/A3/WD.
// A 32-entry scoreboard tracks registers awaiting a long-latency result and
// drives the decode stall.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        rf_wb_arbiter_if.slave (all handshake / RF port signals)
//   conflict_cnt, forced_cnt (16 bits each) exist only when RFARB_STATS_EN
//              is defined: cycles lu was refused, and forced-grant events.
// Parameters:
//   STARVE_MAX refused lu cycles tolerated before a forced grant (1..15)
//   SB_REGS    scoreboard entries, fixed at 32
module rf_wb_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int SB_REGS    = 32
) (
  input  logic clk,
  input  logic rst,
  rf_wb_arbiter_if.slave bus
`ifdef RFARB_STATS_EN
  ,
  output logic [15:0] conflict_cnt,
  output logic [15:0] forced_cnt
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {NORMAL, HOLD} state_t;

  state_t              state, next_state;
  logic [3:0]          starve_cnt;
  logic [4:0]          skid_rd;
  logic [31:0]         skid_wd;
  logic [SB_REGS-1:0]  pending;
  logic                rf_we_q;
  logic [4:0]          rf_a3_q;
  logic [31:0]         rf_wd_q;
  logic                rf_from_lu_q;

  logic                wb_req, lu_req, lu_drop, starved;
  logic                grant_valid, grant_lu, capture, lu_ready;
  logic [4:0]          grant_rd;
  logic [31:0]         grant_wd;
  logic [SB_REGS-1:0]  set_mask, clr_mask;
  logic                id_stall;

  assign wb_req  = bus.wb_we && (bus.wb_rd != 5'd0);
  assign lu_req  = bus.lu_valid && (bus.lu_rd != 5'd0);
  assign lu_drop = bus.lu_valid && (bus.lu_rd == 5'd0);
  assign starved = (starve_cnt == STARVE_LIM) && lu_req;

  // Grant selection. The skid only holds data in HOLD, so the state doubles
  // as the skid-full flag. Results for x0 are acknowledged and dropped in any
  // state without touching the write port.
  always_comb begin
    next_state  = state;
    grant_valid = 1'b0;
    grant_lu    = 1'b0;
    grant_rd    = 5'd0;
    grant_wd    = 32'd0;
    capture     = 1'b0;
    lu_ready    = lu_drop;
    case (state)
      HOLD: begin
        grant_valid = 1'b1;
        grant_rd    = skid_rd;
        grant_wd    = skid_wd;
        next_state  = NORMAL;
      end
      default: begin
        if (starved) begin
          grant_valid = 1'b1;
          grant_lu    = 1'b1;
          grant_rd    = bus.lu_rd;
          grant_wd    = bus.lu_wd;
          lu_ready    = 1'b1;
          if (wb_req) begin
            capture    = 1'b1;
            next_state = HOLD;
          end
        end else if (wb_req) begin
          grant_valid = 1'b1;
          grant_rd    = bus.wb_rd;
          grant_wd    = bus.wb_wd;
        end else if (lu_req) begin
          grant_valid = 1'b1;
          grant_lu    = 1'b1;
          grant_rd    = bus.lu_rd;
          grant_wd    = bus.lu_wd;
          lu_ready    = 1'b1;
        end
      end
    endcase
  end

  // Scoreboard update masks: a long-latency result leaving the write port
  // clears its bit; a new issue sets one. Set wins because it is ORed last.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.lu_issue && (bus.lu_issue_rd != 5'd0))
      set_mask[bus.lu_issue_rd] = 1'b1;
    if (rf_we_q && rf_from_lu_q)
      clr_mask[rf_a3_q] = 1'b1;
  end

  // Decode hazard check against the current scoreboard; x0 never stalls.
  always_comb begin
    id_stall = 1'b0;
    if ((bus.id_rs1 != 5'd0) && pending[bus.id_rs1]) id_stall = 1'b1;
    if ((bus.id_rs2 != 5'd0) && pending[bus.id_rs2]) id_stall = 1'b1;
    if ((bus.id_rd  != 5'd0) && pending[bus.id_rd])  id_stall = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= NORMAL;
    end else begin
      state <= next_state;
    end
  end

  // Write port, skid, starvation counter and scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q      <= 1'b0;
      rf_a3_q      <= 5'd0;
      rf_wd_q      <= 32'd0;
      rf_from_lu_q <= 1'b0;
      skid_rd      <= 5'd0;
      skid_wd      <= 32'd0;
      starve_cnt   <= 4'd0;
      pending      <= '0;
    end else begin
      rf_we_q      <= grant_valid;
      rf_a3_q      <= grant_rd;
      rf_wd_q      <= grant_wd;
      rf_from_lu_q <= grant_lu;
      if (capture) begin
        skid_rd <= bus.wb_rd;
        skid_wd <= bus.wb_wd;
      end
      if (bus.lu_valid && !lu_ready) begin
        if (starve_cnt != STARVE_LIM)
          starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= 4'd0;
      end
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

`ifdef RFARB_STATS_EN
  // Saturating event counters for arbitration conflicts and forced grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= 16'd0;
      forced_cnt   <= 16'd0;
    end else begin
      if (bus.lu_valid && !lu_ready && (conflict_cnt != 16'hFFFF))
        conflict_cnt <= conflict_cnt + 16'd1;
      if ((state == NORMAL) && (next_state == HOLD) && (forced_cnt != 16'hFFFF))
        forced_cnt <= forced_cnt + 16'd1;
    end
  end
`endif

  assign bus.lu_ready  = lu_ready;
  assign bus.id_stall  = id_stall;
  assign bus.pipe_hold = (state == HOLD);
  assign bus.RFWr      = rf_we_q;
  assign bus.A3        = rf_a3_q;
  assign bus.WD        = rf_wd_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter
// Directed testbench for rf_wb_arbiter (STARVE_MAX=4). Inputs change 1 time
// unit after a rising edge; combinational outputs are sampled 1 unit later,
// registered outputs 1 unit after the edge that loads them.
module tb_rf_wb_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rf_wb_arbiter_if bus();

`ifdef RFARB_STATS_EN
  logic [15:0] conflict_cnt;
  logic [15:0] forced_cnt;
`endif

  rf_wb_arbiter #(.STARVE_MAX(4), .SB_REGS(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef RFARB_STATS_EN
    ,
    .conflict_cnt(conflict_cnt),
    .forced_cnt(forced_cnt)
`endif
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.wb_we = 1'b0; bus.wb_rd = 5'd0; bus.wb_wd = 32'd0;
    bus.lu_issue = 1'b0; bus.lu_issue_rd = 5'd0;
    bus.lu_valid = 1'b0; bus.lu_rd = 5'd0; bus.lu_wd = 32'd0;
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_rd = 5'd0;
  endtask

  // Reset with every input active, then a first writeback.
  task automatic test_reset;
    rst = 1'b1;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd5; bus.wb_wd = 32'hFFFF_FFFF;
    bus.lu_issue = 1'b1; bus.lu_issue_rd = 5'd4;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd6; bus.lu_wd = 32'h1;
    bus.id_rs1 = 5'd4; bus.id_rs2 = 5'd5; bus.id_rd = 5'd6;
    step();
    checks++;
    if (bus.RFWr !== 1'b0 || bus.A3 !== 5'd0 || bus.WD !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_port: RFWr=%0b A3=%0d WD=%h expected 0/0/0", bus.RFWr, bus.A3, bus.WD);
    end
    checks++;
    if (bus.pipe_hold !== 1'b0 || bus.id_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: pipe_hold=%0b id_stall=%0b expected 0/0", bus.pipe_hold, bus.id_stall);
    end
    idle();
    rst = 1'b0;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd5; bus.wb_wd = 32'h1234_5678;
    step();
    bus.wb_we = 1'b0;
    checks++;
    if (bus.RFWr !== 1'b1 || bus.A3 !== 5'd5 || bus.WD !== 32'h1234_5678) begin
      failures++;
      $display("[TB] FAIL first_wb: RFWr=%0b A3=%0d WD=%h expected 1/5/12345678", bus.RFWr, bus.A3, bus.WD);
    end
    step();
    checks++;
    if (bus.RFWr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL first_wb_idle: RFWr=%0b expected 0", bus.RFWr);
    end
  endtask

  // wb beats lu in a plain conflict; lu goes next cycle.
  task automatic test_priority;
    idle();
    bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_wd = 32'hAAAA;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd7; bus.lu_wd = 32'hBBBB;
    #1;
    checks++;
    if (bus.lu_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL prio_lu_refused: lu_ready=%0b expected 0", bus.lu_ready);
    end
    step();
    bus.wb_we = 1'b0;
    checks++;
    if (bus.RFWr !== 1'b1 || bus.A3 !== 5'd3 || bus.WD !== 32'hAAAA) begin
      failures++;
      $display("[TB] FAIL prio_wb_write: RFWr=%0b A3=%0d WD=%h expected 1/3/aaaa", bus.RFWr, bus.A3, bus.WD);
    end
    #1;
    checks++;
    if (bus.lu_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL prio_lu_grant: lu_ready=%0b expected 1", bus.lu_ready);
    end
    step();
    bus.lu_valid = 1'b0;
    checks++;
    if (bus.RFWr !== 1'b1 || bus.A3 !== 5'd7 || bus.WD !== 32'hBBBB) begin
      failures++;
      $display("[TB] FAIL prio_lu_write: RFWr=%0b A3=%0d WD=%h expected 1/7/bbbb", bus.RFWr, bus.A3, bus.WD);
    end
    step();
    checks++;
    if (bus.RFWr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL prio_idle: RFWr=%0b expected 0", bus.RFWr);
    end
  endtask

  // Starvation: four wb wins, forced lu grant with skid capture, HOLD drain.
  task automatic test_starve;
    logic        exp_ready;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd;
    idle();
    bus.wb_we = 1'b1; bus.wb_rd = 5'd2;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd9; bus.lu_wd = 32'h99;
    for (int i = 1; i <= 5; i++) begin
      bus.wb_wd = 32'h200 + 32'(i);
      #1;
      exp_ready = (i == 5);
      checks++;
      if (bus.lu_ready !== exp_ready) begin
        failures++;
        $display("[TB] FAIL starve_ready cycle %0d: lu_ready=%0b expected %0b", i, bus.lu_ready, exp_ready);
      end
      step();
      exp_a3 = (i == 5) ? 5'd9 : 5'd2;
      exp_wd = (i == 5) ? 32'h99 : (32'h200 + 32'(i));
      checks++;
      if (bus.RFWr !== 1'b1 || bus.A3 !== exp_a3 || bus.WD !== exp_wd) begin
        failures++;
        $display("[TB] FAIL starve_write cycle %0d: RFWr=%0b A3=%0d WD=%h expected 1/%0d/%h", i, bus.RFWr, bus.A3, bus.WD, exp_a3, exp_wd);
      end
    end
    bus.wb_we = 1'b0;
    bus.lu_rd = 5'd11; bus.lu_wd = 32'hBB;
    #1;
    checks++;
    if (bus.pipe_hold !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hold_flag: pipe_hold=%0b expected 1", bus.pipe_hold);
    end
    checks++;
    if (bus.lu_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_no_lu: lu_ready=%0b expected 0", bus.lu_ready);
    end
    step();
    checks++;
    if (bus.RFWr !== 1'b1 || bus.A3 !== 5'd2 || bus.WD !== 32'h205 || bus.pipe_hold !== 1'b0) begin
      failures++;
      $display("[TB] FAIL skid_write: RFWr=%0b A3=%0d WD=%h hold=%0b expected 1/2/205/0", bus.RFWr, bus.A3, bus.WD, bus.pipe_hold);
    end
    #1;
    checks++;
    if (bus.lu_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL after_hold_lu: lu_ready=%0b expected 1", bus.lu_ready);
    end
    step();
    bus.lu_valid = 1'b0;
    checks++;
    if (bus.RFWr !== 1'b1 || bus.A3 !== 5'd11 || bus.WD !== 32'hBB) begin
      failures++;
      $display("[TB] FAIL after_hold_write: RFWr=%0b A3=%0d WD=%h expected 1/11/bb", bus.RFWr, bus.A3, bus.WD);
    end
    step();
  endtask

  // Scoreboard set, stall, wb-no-clear, lu clear and same-cycle set priority.
  task automatic test_scoreboard;
    idle();
    bus.lu_issue = 1'b1; bus.lu_issue_rd = 5'd10; bus.id_rs1 = 5'd10;
    #1;
    checks++;
    if (bus.id_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sb_no_lookahead: id_stall=%0b expected 0", bus.id_stall);
    end
    step();
    bus.lu_issue = 1'b0;
    #1;
    checks++;
    if (bus.id_stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sb_rs1_stall: id_stall=%0b expected 1", bus.id_stall);
    end
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd10;
    #1;
    checks++;
    if (bus.id_stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sb_rs2_stall: id_stall=%0b expected 1", bus.id_stall);
    end
    bus.id_rs2 = 5'd0; bus.id_rd = 5'd10;
    #1;
    checks++;
    if (bus.id_stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sb_rd_stall: id_stall=%0b expected 1", bus.id_stall);
    end
    bus.id_rd = 5'd0;
    #1;
    checks++;
    if (bus.id_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sb_x0_nostall: id_stall=%0b expected 0", bus.id_stall);
    end
    bus.id_rs1 = 5'd10;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd10; bus.wb_wd = 32'h77;
    step();
    bus.wb_we = 1'b0;
    step();
    checks++;
    if (bus.id_stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sb_wb_no_clear: id_stall=%0b expected 1", bus.id_stall);
    end
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd10; bus.lu_wd = 32'hA0;
    step();
    bus.lu_valid = 1'b0;
    bus.lu_issue = 1'b1; bus.lu_issue_rd = 5'd10;
    checks++;
    if (bus.RFWr !== 1'b1 || bus.A3 !== 5'd10 || bus.id_stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sb_result_cycle: RFWr=%0b A3=%0d stall=%0b expected 1/10/1", bus.RFWr, bus.A3, bus.id_stall);
    end
    step();
    bus.lu_issue = 1'b0;
    checks++;
    if (bus.id_stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sb_set_wins: id_stall=%0b expected 1", bus.id_stall);
    end
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd10; bus.lu_wd = 32'hA1;
    step();
    bus.lu_valid = 1'b0;
    checks++;
    if (bus.id_stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sb_stall_during_write: id_stall=%0b expected 1", bus.id_stall);
    end
    step();
    checks++;
    if (bus.id_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sb_cleared: id_stall=%0b expected 0", bus.id_stall);
    end
  endtask

  // Writes addressed to x0.
  task automatic test_x0;
    idle();
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd0; bus.lu_wd = 32'hDEAD;
    #1;
    checks++;
    if (bus.lu_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL x0_lu_drop: lu_ready=%0b expected 1", bus.lu_ready);
    end
    step();
    checks++;
    if (bus.RFWr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL x0_lu_nowrite: RFWr=%0b expected 0", bus.RFWr);
    end
    bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_wd = 32'hBEEF;
    bus.lu_rd = 5'd6; bus.lu_wd = 32'h66;
    #1;
    checks++;
    if (bus.lu_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL x0_wb_lu_grant: lu_ready=%0b expected 1", bus.lu_ready);
    end
    step();
    idle();
    checks++;
    if (bus.RFWr !== 1'b1 || bus.A3 !== 5'd6 || bus.WD !== 32'h66) begin
      failures++;
      $display("[TB] FAIL x0_wb_ignored: RFWr=%0b A3=%0d WD=%h expected 1/6/66", bus.RFWr, bus.A3, bus.WD);
    end
    step();
  endtask

  // Asynchronous reset with the skid full and pending[4] set.
  task automatic test_reset_mid;
    idle();
    bus.lu_issue = 1'b1; bus.lu_issue_rd = 5'd4;
    step();
    bus.lu_issue = 1'b0;
    bus.id_rs1 = 5'd4;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd2; bus.wb_wd = 32'h55;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd9; bus.lu_wd = 32'h99;
    for (int i = 0; i < 5; i++) step();
    bus.wb_we = 1'b0; bus.lu_valid = 1'b0;
    #1;
    checks++;
    if (bus.pipe_hold !== 1'b1 || bus.id_stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_setup: pipe_hold=%0b id_stall=%0b expected 1/1", bus.pipe_hold, bus.id_stall);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.RFWr !== 1'b0 || bus.A3 !== 5'd0 || bus.WD !== 32'd0 || bus.pipe_hold !== 1'b0 || bus.id_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_async_clear: RFWr=%0b A3=%0d WD=%h hold=%0b stall=%0b expected all 0", bus.RFWr, bus.A3, bus.WD, bus.pipe_hold, bus.id_stall);
    end
`ifdef RFARB_STATS_EN
    checks++;
    if (conflict_cnt !== 16'd0 || forced_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL mid_stats: conflict=%0d forced=%0d expected 0/0", conflict_cnt, forced_cnt);
    end
`endif
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.RFWr !== 1'b0 || bus.pipe_hold !== 1'b0) begin
        failures++;
        $display("[TB] FAIL mid_no_write cycle %0d: RFWr=%0b hold=%0b expected 0/0", i, bus.RFWr, bus.pipe_hold);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle();
    test_reset();
    test_priority();
    test_starve();
    test_scoreboard();
    test_x0();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
